dcache_wb: RTL and testbench

DCACHE_WB -- requirements
Module: dcache_wb

---
 rtl/dcache_wb_if.sv | 48 ++++
 rtl/dcache_wb.sv | 236 +++++++++++++++++++++++
 tb/tb_dcache_wb.sv | 441 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_wb_if.sv
// Consumer request/response ports and controller fill/writeback channel of the write-back data cache.
interface dcache_wb_if #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;

    logic                 controller_read_valid;
    logic [ADDR_BITS-1:0] controller_read_address;
    logic                 controller_read_ready;
    logic [DATA_BITS-1:0] controller_read_data;
    logic                 controller_write_valid;
    logic [ADDR_BITS-1:0] controller_write_address;
    logic [DATA_BITS-1:0] controller_write_data;
    logic                 controller_write_ready;

    // Cache side
    modport slave (
        input  consumer_read_valid, consumer_read_address,
        output consumer_read_ready, consumer_read_data,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        output consumer_write_ready,
        output controller_read_valid, controller_read_address,
        input  controller_read_ready, controller_read_data,
        output controller_write_valid, controller_write_address, controller_write_data,
        input  controller_write_ready
    );

    // Consumers plus memory controller side
    modport master (
        output consumer_read_valid, consumer_read_address,
        input  consumer_read_ready, consumer_read_data,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        input  consumer_write_ready,
        input  controller_read_valid, controller_read_address,
        output controller_read_ready, controller_read_data,
        input  controller_write_valid, controller_write_address, controller_write_data,
        output controller_write_ready
    );
endinterface

// File: rtl/dcache_wb.sv
// Multi-consumer, set-associative, write-back/write-allocate data cache with one-word lines,
// round-robin arbitration, FIFO replacement and a full flush of dirty lines.
module dcache_wb #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_SETS      = 4,
    parameter int unsigned NUM_WAYS      = 2
) (
    input  logic       clk,
    input  logic       reset,
    dcache_wb_if.slave bus,
    input  logic       flush_valid,
    output logic       flush_done
);
    localparam int unsigned SET_BITS  = $clog2(NUM_SETS);
    localparam int unsigned TAG_BITS  = ADDR_BITS - SET_BITS;
    localparam int unsigned WAY_BITS  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int unsigned CONS_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESPOND, RELEASE, FLUSH} state_t;

    state_t state;

    logic [NUM_WAYS-1:0]  line_valid [NUM_SETS];
    logic [NUM_WAYS-1:0]  line_dirty [NUM_SETS];
    logic [TAG_BITS-1:0]  line_tag   [NUM_SETS][NUM_WAYS];
    logic [DATA_BITS-1:0] line_data  [NUM_SETS][NUM_WAYS];
    logic [WAY_BITS-1:0]  fifo_ptr   [NUM_SETS];

    logic [CONS_BITS-1:0] grant, last_grant;
    logic                 req_write;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_wdata, resp_data;
    logic [WAY_BITS-1:0]  victim;
    logic [SET_BITS-1:0]  flush_set;
    logic [WAY_BITS-1:0]  flush_way;

    logic [SET_BITS-1:0]  req_set;
    logic [TAG_BITS-1:0]  req_tag;
    assign req_set = req_addr[SET_BITS-1:0];
    assign req_tag = req_addr[ADDR_BITS-1:SET_BITS];

    // Tag compare and victim choice for the latched request
    logic                hit_c, inv_found_c;
    logic [WAY_BITS-1:0] hit_way_c, inv_way_c, victim_c, fifo_next_c;
    always_comb begin
        hit_c       = 1'b0;
        hit_way_c   = '0;
        inv_found_c = 1'b0;
        inv_way_c   = '0;
        for (int w = 0; w < int'(NUM_WAYS); w++) begin
            if (!hit_c && line_valid[req_set][w] && (line_tag[req_set][w] == req_tag)) begin
                hit_c     = 1'b1;
                hit_way_c = WAY_BITS'(w);
            end
            if (!inv_found_c && !line_valid[req_set][w]) begin
                inv_found_c = 1'b1;
                inv_way_c   = WAY_BITS'(w);
            end
        end
        victim_c    = inv_found_c ? inv_way_c : fifo_ptr[req_set];
        fifo_next_c = (fifo_ptr[req_set] == WAY_BITS'(NUM_WAYS - 1)) ? '0 : fifo_ptr[req_set] + 1'b1;
    end

    // Round-robin search starting after the last granted consumer
    logic                 gnt_found_c;
    logic [CONS_BITS-1:0] gnt_idx_c, cand_c;
    always_comb begin
        gnt_found_c = 1'b0;
        gnt_idx_c   = '0;
        cand_c      = '0;
        for (int i = 1; i <= int'(NUM_CONSUMERS); i++) begin
            cand_c = CONS_BITS'((int'(last_grant) + i) % int'(NUM_CONSUMERS));
            if (!gnt_found_c && (bus.consumer_read_valid[cand_c] || bus.consumer_write_valid[cand_c])) begin
                gnt_found_c = 1'b1;
                gnt_idx_c   = cand_c;
            end
        end
    end

    logic flush_last_c, flush_dirty_c, flush_step_c;
    always_comb begin
        flush_last_c  = (flush_way == WAY_BITS'(NUM_WAYS - 1)) && (flush_set == SET_BITS'(NUM_SETS - 1));
        flush_dirty_c = line_valid[flush_set][flush_way] && line_dirty[flush_set][flush_way];
        flush_step_c  = bus.controller_write_valid ? bus.controller_write_ready : !flush_dirty_c;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                        <= IDLE;
            grant                        <= '0;
            last_grant                   <= CONS_BITS'(NUM_CONSUMERS - 1);
            req_write                    <= 1'b0;
            req_addr                     <= '0;
            req_wdata                    <= '0;
            resp_data                    <= '0;
            victim                       <= '0;
            flush_set                    <= '0;
            flush_way                    <= '0;
            flush_done                   <= 1'b0;
            bus.consumer_read_ready      <= '0;
            bus.consumer_read_data       <= '0;
            bus.consumer_write_ready     <= '0;
            bus.controller_read_valid    <= 1'b0;
            bus.controller_read_address  <= '0;
            bus.controller_write_valid   <= 1'b0;
            bus.controller_write_address <= '0;
            bus.controller_write_data    <= '0;
            for (int s = 0; s < int'(NUM_SETS); s++) begin
                line_valid[s] <= '0;
                line_dirty[s] <= '0;
                fifo_ptr[s]   <= '0;
                for (int w = 0; w < int'(NUM_WAYS); w++) begin
                    line_tag[s][w]  <= '0;
                    line_data[s][w] <= '0;
                end
            end
        end else begin
            bus.consumer_read_ready  <= '0;
            bus.consumer_read_data   <= '0;
            bus.consumer_write_ready <= '0;
            flush_done               <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush_valid) begin
                        flush_set <= '0;
                        flush_way <= '0;
                        state     <= FLUSH;
                    end else if (gnt_found_c) begin
                        grant      <= gnt_idx_c;
                        last_grant <= gnt_idx_c;
                        req_write  <= !bus.consumer_read_valid[gnt_idx_c];
                        req_addr   <= bus.consumer_read_valid[gnt_idx_c] ? bus.consumer_read_address[gnt_idx_c]
                                                                         : bus.consumer_write_address[gnt_idx_c];
                        req_wdata  <= bus.consumer_write_data[gnt_idx_c];
                        state      <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit_c) begin
                        if (req_write) begin
                            line_data[req_set][hit_way_c]  <= req_wdata;
                            line_dirty[req_set][hit_way_c] <= 1'b1;
                        end else begin
                            resp_data <= line_data[req_set][hit_way_c];
                        end
                        state <= RESPOND;
                    end else begin
                        victim <= victim_c;
                        if (!inv_found_c) fifo_ptr[req_set] <= fifo_next_c;
                        if (line_valid[req_set][victim_c] && line_dirty[req_set][victim_c]) begin
                            bus.controller_write_valid   <= 1'b1;
                            bus.controller_write_address <= {line_tag[req_set][victim_c], req_set};
                            bus.controller_write_data    <= line_data[req_set][victim_c];
                            state                        <= WRITEBACK;
                        end else if (req_write) begin
                            // Write-allocate without a fill: the word is the whole line
                            line_valid[req_set][victim_c] <= 1'b1;
                            line_dirty[req_set][victim_c] <= 1'b1;
                            line_tag[req_set][victim_c]   <= req_tag;
                            line_data[req_set][victim_c]  <= req_wdata;
                            state                         <= RESPOND;
                        end else begin
                            bus.controller_read_valid   <= 1'b1;
                            bus.controller_read_address <= req_addr;
                            state                       <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.controller_write_ready) begin
                        bus.controller_write_valid  <= 1'b0;
                        line_dirty[req_set][victim] <= req_write;
                        if (req_write) begin
                            line_valid[req_set][victim] <= 1'b1;
                            line_tag[req_set][victim]   <= req_tag;
                            line_data[req_set][victim]  <= req_wdata;
                            state                       <= RESPOND;
                        end else begin
                            bus.controller_read_valid   <= 1'b1;
                            bus.controller_read_address <= req_addr;
                            state                       <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (bus.controller_read_ready) begin
                        bus.controller_read_valid   <= 1'b0;
                        line_valid[req_set][victim] <= 1'b1;
                        line_dirty[req_set][victim] <= 1'b0;
                        line_tag[req_set][victim]   <= req_tag;
                        line_data[req_set][victim]  <= bus.controller_read_data;
                        resp_data                   <= bus.controller_read_data;
                        state                       <= RESPOND;
                    end
                end
                RESPOND: begin
                    if (req_write) begin
                        bus.consumer_write_ready[grant] <= 1'b1;
                    end else begin
                        bus.consumer_read_ready[grant] <= 1'b1;
                        bus.consumer_read_data[grant]  <= resp_data;
                    end
                    state <= RELEASE;
                end
                RELEASE: begin
                    if (!(req_write ? bus.consumer_write_valid[grant] : bus.consumer_read_valid[grant])) state <= IDLE;
                end
                FLUSH: begin
                    if (bus.controller_write_valid && bus.controller_write_ready) begin
                        bus.controller_write_valid        <= 1'b0;
                        line_dirty[flush_set][flush_way]  <= 1'b0;
                    end else if (!bus.controller_write_valid && flush_dirty_c) begin
                        bus.controller_write_valid   <= 1'b1;
                        bus.controller_write_address <= {line_tag[flush_set][flush_way], flush_set};
                        bus.controller_write_data    <= line_data[flush_set][flush_way];
                    end
                    if (flush_step_c) begin
                        if (flush_way == WAY_BITS'(NUM_WAYS - 1)) begin
                            flush_way <= '0;
                            flush_set <= flush_set + 1'b1;
                        end else begin
                            flush_way <= flush_way + 1'b1;
                        end
                        if (flush_last_c) begin
                            flush_done <= 1'b1;
                            state      <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Scenario bench for dcache_wb: expected bus events are queued as stimulus is issued and
// compared in order against events observed on the consumer and controller channels.
module tb_dcache_wb;
    localparam int EV_RD  = 1;
    localparam int EV_WR  = 2;
    localparam int EV_CRD = 3;
    localparam int EV_CWR = 4;
    localparam int EV_FD  = 5;

    typedef struct packed {
        logic [3:0] kind;
        logic [3:0] port;
        logic [7:0] addr;
        logic [7:0] data;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic flush_valid;
    logic flush_done;

    always #5 clk = ~clk;

    dcache_wb_if #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4)) bus ();

    dcache_wb #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_SETS(4), .NUM_WAYS(2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus.slave),
        .flush_valid(flush_valid),
        .flush_done (flush_done)
    );

    ev_t        exp_q[$];
    ev_t        obs_q[$];
    int         obs_edge[$];
    int         edges;
    int         n_checks;
    int         n_pass;
    logic [7:0] mem [256];
    bit         mem_hold;
    int         rd_cnt;
    int         wr_cnt;

    function automatic ev_t mk(int k, int p, int a, int d);
        mk = {4'(k), 4'(p), 8'(a), 8'(d)};
    endfunction

    function automatic logic [66:0] dut_outs();
        return {bus.consumer_read_ready, bus.consumer_read_data, bus.consumer_write_ready,
                bus.controller_read_valid, bus.controller_read_address,
                bus.controller_write_valid, bus.controller_write_address, bus.controller_write_data,
                flush_done};
    endfunction

    // One clock: record events mid-cycle, then act as memory controller and consumers after the edge
    task automatic tick();
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            if (bus.consumer_read_ready[p]) begin
                obs_q.push_back(mk(EV_RD, p, 0, int'(bus.consumer_read_data[p])));
                obs_edge.push_back(edges);
            end
            if (bus.consumer_write_ready[p]) begin
                obs_q.push_back(mk(EV_WR, p, 0, 0));
                obs_edge.push_back(edges);
            end
        end
        if (bus.controller_read_valid && bus.controller_read_ready) begin
            obs_q.push_back(mk(EV_CRD, 0, int'(bus.controller_read_address), int'(bus.controller_read_data)));
            obs_edge.push_back(edges);
        end
        if (bus.controller_write_valid && bus.controller_write_ready) begin
            obs_q.push_back(mk(EV_CWR, 0, int'(bus.controller_write_address), int'(bus.controller_write_data)));
            obs_edge.push_back(edges);
        end
        if (flush_done) begin
            obs_q.push_back(mk(EV_FD, 0, 0, 0));
            obs_edge.push_back(edges);
        end
        @(posedge clk);
        edges++;
        #1;
        if (bus.controller_read_ready) begin
            bus.controller_read_ready = 1'b0;
            rd_cnt = 0;
        end else if (bus.controller_read_valid && !mem_hold) begin
            if (rd_cnt >= 1) begin
                bus.controller_read_ready = 1'b1;
                bus.controller_read_data  = mem[bus.controller_read_address];
            end else rd_cnt++;
        end else rd_cnt = 0;
        if (bus.controller_write_ready) begin
            bus.controller_write_ready = 1'b0;
            wr_cnt = 0;
        end else if (bus.controller_write_valid) begin
            if (wr_cnt >= 1) bus.controller_write_ready = 1'b1;
            else wr_cnt++;
        end else wr_cnt = 0;
        for (int p = 0; p < 4; p++) begin
            if (bus.consumer_read_ready[p])  bus.consumer_read_valid[p]  = 1'b0;
            if (bus.consumer_write_ready[p]) bus.consumer_write_valid[p] = 1'b0;
        end
    endtask

    task automatic idle(int n);
        repeat (n) tick();
    endtask

    task automatic wait_obs(int n, int budget);
        int k = 0;
        while (obs_q.size() < n && k < budget) begin
            tick();
            k++;
        end
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_edge.delete();
    endtask

    task automatic drive_read(int p, int a);
        int k = 0;
        bus.consumer_read_valid[p]   = 1'b1;
        bus.consumer_read_address[p] = 8'(a);
        while (bus.consumer_read_valid[p] && k < 200) begin
            tick();
            k++;
        end
        idle(2);
    endtask

    task automatic drive_write(int p, int a, int d);
        int k = 0;
        bus.consumer_write_valid[p]   = 1'b1;
        bus.consumer_write_address[p] = 8'(a);
        bus.consumer_write_data[p]    = 8'(d);
        while (bus.consumer_write_valid[p] && k < 200) begin
            tick();
            k++;
        end
        idle(2);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        bus.consumer_read_valid    = '0;
        bus.consumer_write_valid   = '0;
        bus.controller_read_ready  = 1'b0;
        bus.controller_write_ready = 1'b0;
        flush_valid = 1'b0;
        mem_hold    = 1'b0;
        rd_cnt      = 0;
        wr_cnt      = 0;
        idle(2);
        reset = 1'b1;
        idle(2);
        clear_queues();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush_valid = 1'b0;
        bus.consumer_read_valid    = '0;
        bus.consumer_read_address  = '0;
        bus.consumer_write_valid   = '0;
        bus.consumer_write_address = '0;
        bus.consumer_write_data    = '0;
        bus.controller_read_ready  = 1'b0;
        bus.controller_read_data   = '0;
        bus.controller_write_ready = 1'b0;
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (dut_outs() !== '0) $display("FAIL reset_async outputs: got %h expected 0", dut_outs());
        else n_pass++;
        idle(3);
        n_checks++;
        if (dut_outs() !== '0) $display("FAIL reset_held outputs: got %h expected 0", dut_outs());
        else n_pass++;
        reset = 1'b1;
        idle(3);
        n_checks++;
        if (dut_outs() !== '0) $display("FAIL reset_idle outputs: got %h expected 0", dut_outs());
        else n_pass++;
        clear_queues();
    endtask

    task automatic test_cold_read();
        ev_t e, o;
        int  e0, lat;
        mem[8'h10] = 8'hAB;
        exp_q.push_back(mk(EV_CRD, 0, 'h10, 'hAB));
        exp_q.push_back(mk(EV_RD, 0, 0, 'hAB));
        drive_read(0, 'h10);
        wait_obs(2, 50);
        idle(3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL cold_read event: got %h expected %h", o, e);
            else n_pass++;
        end
        // Repeat read must hit with fixed latency and no controller traffic
        clear_queues();
        exp_q.push_back(mk(EV_RD, 0, 0, 'hAB));
        e0 = edges;
        bus.consumer_read_valid[0]   = 1'b1;
        bus.consumer_read_address[0] = 8'h10;
        wait_obs(1, 50);
        lat = (obs_edge.size() > 0) ? obs_edge[0] - e0 : -1;
        n_checks++;
        if (lat != 3) $display("FAIL hit_latency edges: got %0d expected 3", lat);
        else n_pass++;
        idle(6);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL hit_read event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL hit_read extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_writeback();
        ev_t e, o;
        do_reset();
        mem[8'h08] = 8'h11;
        mem[8'h0C] = 8'h22;
        exp_q.push_back(mk(EV_WR, 0, 0, 0));
        drive_write(0, 'h04, 'h55);
        exp_q.push_back(mk(EV_CRD, 0, 'h08, 'h11));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h11));
        drive_read(0, 'h08);
        exp_q.push_back(mk(EV_CWR, 0, 'h04, 'h55));
        exp_q.push_back(mk(EV_CRD, 0, 'h0C, 'h22));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h22));
        drive_read(0, 'h0C);
        wait_obs(6, 50);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL writeback event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL writeback extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_round_robin();
        ev_t e, o;
        int  k;
        do_reset();
        mem[8'h21] = 8'h31;
        mem[8'h22] = 8'h32;
        exp_q.push_back(mk(EV_CRD, 0, 'h21, 'h31));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h31));
        drive_read(0, 'h21);
        exp_q.push_back(mk(EV_CRD, 0, 'h22, 'h32));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h32));
        drive_read(0, 'h22);
        exp_q.push_back(mk(EV_RD, 1, 0, 'h31));
        exp_q.push_back(mk(EV_RD, 3, 0, 'h32));
        bus.consumer_read_address[1] = 8'h21;
        bus.consumer_read_address[3] = 8'h22;
        bus.consumer_read_valid[1]   = 1'b1;
        bus.consumer_read_valid[3]   = 1'b1;
        k = 0;
        while ((bus.consumer_read_valid[1] || bus.consumer_read_valid[3]) && k < 100) begin tick(); k++; end
        idle(3);
        exp_q.push_back(mk(EV_RD, 0, 0, 'h31));
        exp_q.push_back(mk(EV_RD, 1, 0, 'h32));
        bus.consumer_read_address[0] = 8'h21;
        bus.consumer_read_address[1] = 8'h22;
        bus.consumer_read_valid[0]   = 1'b1;
        bus.consumer_read_valid[1]   = 1'b1;
        k = 0;
        while ((bus.consumer_read_valid[0] || bus.consumer_read_valid[1]) && k < 100) begin tick(); k++; end
        wait_obs(8, 50);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL round_robin event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL round_robin extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_read_write_same_port();
        ev_t e, o;
        int  k;
        do_reset();
        mem[8'h33] = 8'h44;
        exp_q.push_back(mk(EV_CRD, 0, 'h33, 'h44));
        exp_q.push_back(mk(EV_RD, 2, 0, 'h44));
        drive_read(2, 'h33);
        exp_q.push_back(mk(EV_RD, 2, 0, 'h44));
        exp_q.push_back(mk(EV_WR, 2, 0, 0));
        bus.consumer_read_address[2]  = 8'h33;
        bus.consumer_write_address[2] = 8'h33;
        bus.consumer_write_data[2]    = 8'h99;
        bus.consumer_read_valid[2]    = 1'b1;
        bus.consumer_write_valid[2]   = 1'b1;
        k = 0;
        while ((bus.consumer_read_valid[2] || bus.consumer_write_valid[2]) && k < 100) begin tick(); k++; end
        idle(2);
        exp_q.push_back(mk(EV_RD, 0, 0, 'h99));
        drive_read(0, 'h33);
        wait_obs(5, 50);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL rw_priority event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL rw_priority extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_flush();
        ev_t e, o;
        do_reset();
        mem[8'h02] = 8'h5A;
        exp_q.push_back(mk(EV_WR, 0, 0, 0));
        drive_write(0, 'h40, 'hA1);
        exp_q.push_back(mk(EV_CRD, 0, 'h02, 'h5A));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h5A));
        drive_read(0, 'h02);
        exp_q.push_back(mk(EV_WR, 0, 0, 0));
        drive_write(0, 'h06, 'hB2);
        idle(3);
        exp_q.push_back(mk(EV_CWR, 0, 'h40, 'hA1));
        exp_q.push_back(mk(EV_CWR, 0, 'h06, 'hB2));
        exp_q.push_back(mk(EV_FD, 0, 0, 0));
        flush_valid = 1'b1;
        tick();
        flush_valid = 1'b0;
        wait_obs(7, 100);
        idle(3);
        exp_q.push_back(mk(EV_RD, 0, 0, 'hA1));
        drive_read(0, 'h40);
        exp_q.push_back(mk(EV_RD, 0, 0, 'hB2));
        drive_read(0, 'h06);
        wait_obs(9, 50);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL flush event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL flush extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid_fill();
        ev_t e, o;
        int  k;
        do_reset();
        mem[8'h50] = 8'h66;
        mem_hold = 1'b1;
        bus.consumer_read_address[0] = 8'h50;
        bus.consumer_read_valid[0]   = 1'b1;
        k = 0;
        while (!bus.controller_read_valid && k < 20) begin tick(); k++; end
        n_checks++;
        if (bus.controller_read_valid !== 1'b1) $display("FAIL mid_fill read_valid: got %b expected 1", bus.controller_read_valid);
        else n_pass++;
        reset = 1'b0;
        #1;
        n_checks++;
        if (dut_outs() !== '0) $display("FAIL mid_fill reset outputs: got %h expected 0", dut_outs());
        else n_pass++;
        idle(3);
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL mid_fill events during reset: got %0d expected 0", obs_q.size());
        else n_pass++;
        mem_hold = 1'b0;
        reset = 1'b1;
        exp_q.push_back(mk(EV_CRD, 0, 'h50, 'h66));
        exp_q.push_back(mk(EV_RD, 0, 0, 'h66));
        wait_obs(2, 50);
        idle(4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (obs_q.size() > 0) begin o = obs_q.pop_front(); void'(obs_edge.pop_front()); end
            else o = '1;
            n_checks++;
            if (o !== e) $display("FAIL mid_fill event: got %h expected %h", o, e);
            else n_pass++;
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL mid_fill extra events: got %0d expected 0", obs_q.size());
        else n_pass++;
    endtask

    initial begin
        edges    = 0;
        n_checks = 0;
        n_pass   = 0;
        mem_hold = 1'b0;
        rd_cnt   = 0;
        wr_cnt   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i);
        test_reset();
        test_cold_read();
        test_writeback();
        test_round_robin();
        test_read_write_same_port();
        test_flush();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
